// File: rtl/tt_lf_pkg.sv
// Shared types and the up/down error decode for the tt_loop_filter PI loop filter.
package tt_lf_pkg;

  typedef enum logic {
    LF_ACQUIRE,
    LF_TRACK
  } lf_state_e;

  typedef enum logic [1:0] {
    SGN_NONE,
    SGN_POS,
    SGN_NEG
  } lf_sign_e;

  // +1 when only up is high, -1 when only down is high, 0 otherwise (both high cancel).
  function automatic logic signed [1:0] lf_err_decode(input logic up, input logic down);
    if (up && !down) begin
      return 2'sb01;
    end else if (down && !up) begin
      return 2'sb11;
    end else begin
      return 2'sb00;
    end
  endfunction

  function automatic lf_sign_e lf_err_sign(input logic signed [1:0] err);
    unique case (err)
      2'sb01:  return SGN_POS;
      2'sb11:  return SGN_NEG;
      default: return SGN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tt_lf_sat_add.sv
// Unsigned value plus signed offset, clamped to [0, 2^OUT_W-1]; sat flags a clamp.
module tt_lf_sat_add #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ADD_W = 8,
  parameter int unsigned OUT_W = 8
) (
  input  logic        [IN_W-1:0]  a,
  input  logic signed [ADD_W-1:0] b,
  output logic        [OUT_W-1:0] y,
  output logic                    sat
);

  localparam int unsigned MAX_IN = (IN_W > ADD_W) ? IN_W : ADD_W;
  localparam int unsigned SUM_W  = ((MAX_IN > OUT_W) ? MAX_IN : OUT_W) + 2;

  logic signed [SUM_W-1:0] a_ext;
  logic signed [SUM_W-1:0] b_ext;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] max_v;

  always_comb begin
    a_ext = $signed({{(SUM_W-IN_W){1'b0}}, a});
    b_ext = {{(SUM_W-ADD_W){b[ADD_W-1]}}, b};
    max_v = $signed({{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}});
    sum   = a_ext + b_ext;
    y     = sum[OUT_W-1:0];
    sat   = 1'b0;
    if (sum < 0) begin
      y   = '0;
      sat = 1'b1;
    end else if (sum > max_v) begin
      y   = '1;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/tt_loop_filter.sv
// PI loop filter: saturating integrator plus one-cycle proportional kick, gain-scheduled FSM.
// Define TT_LF_LOCK_DET_EN to build the lock detector behind o_locked.
module tt_loop_filter
  import tt_lf_pkg::*;
#(
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned FRAC_W    = 6,
  parameter int unsigned INIT_CTRL = 128,
  parameter int unsigned ACQ_STEP  = 64,
  parameter int unsigned TRK_STEP  = 4,
  parameter int unsigned KP_ACQ    = 4,
  parameter int unsigned KP_TRK    = 1,
  parameter int unsigned REV_CNT   = 4,
  parameter int unsigned SLIP_CNT  = 8,
  parameter int unsigned LOCK_CYC  = 256
) (
  input  logic              i_clk_gen,
  input  logic              i_rst,
  input  logic              i_up,
  input  logic              i_down,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_tracking,
  output logic              o_sat,
  output logic              o_locked,
  input  logic              i_scan_en,
  input  logic              i_scan_in,
  output logic              o_scan_out
);

  localparam int unsigned INT_W  = CTRL_W + FRAC_W;
  localparam int unsigned REV_W  = $clog2(REV_CNT + 1);
  localparam int unsigned SLIP_W = $clog2(SLIP_CNT + 1);
  localparam logic [INT_W-1:0]  ACC_INIT  = INT_W'(INIT_CTRL << FRAC_W);
  localparam logic [CTRL_W-1:0] CTRL_INIT = CTRL_W'(INIT_CTRL);

  logic [INT_W-1:0]  acc_q, acc_sum;
  logic [CTRL_W-1:0] ctrl_q, ctrl_sum;
  logic              sat_q, acc_sat;
  logic              ctrl_clamp;
  lf_state_e         state_q, state_d;
  lf_sign_e          last_q, last_d, cur_sign;
  logic [REV_W-1:0]  rev_q, rev_d;
  logic [SLIP_W-1:0] slip_q, slip_d;

  logic signed [1:0]      err;
  logic signed [INT_W:0]  step_mag, step;
  logic signed [CTRL_W:0] kick_mag, kick;

  assign err      = lf_err_decode(i_up, i_down);
  assign cur_sign = lf_err_sign(err);

  always_comb begin
    step_mag = (state_q == LF_TRACK) ? $signed((INT_W+1)'(TRK_STEP))
                                     : $signed((INT_W+1)'(ACQ_STEP));
    kick_mag = (state_q == LF_TRACK) ? $signed((CTRL_W+1)'(KP_TRK))
                                     : $signed((CTRL_W+1)'(KP_ACQ));
    case (err)
      2'sb01: begin
        step = step_mag;
        kick = kick_mag;
      end
      2'sb11: begin
        step = -step_mag;
        kick = -kick_mag;
      end
      default: begin
        step = '0;
        kick = '0;
      end
    endcase
  end

  tt_lf_sat_add #(
    .IN_W (INT_W),
    .ADD_W(INT_W + 1),
    .OUT_W(INT_W)
  ) u_int_add (
    .a  (acc_q),
    .b  (step),
    .y  (acc_sum),
    .sat(acc_sat)
  );

  // Output clamp is not reported on o_sat; only the integrator bound is.
  tt_lf_sat_add #(
    .IN_W (CTRL_W),
    .ADD_W(CTRL_W + 1),
    .OUT_W(CTRL_W)
  ) u_out_add (
    .a  (acc_sum[INT_W-1:FRAC_W]),
    .b  (kick),
    .y  (ctrl_sum),
    .sat(ctrl_clamp)
  );

  always_comb begin
    state_d = state_q;
    rev_d   = rev_q;
    slip_d  = slip_q;
    last_d  = last_q;
    if (cur_sign != SGN_NONE) begin
      last_d = cur_sign;
      unique case (state_q)
        LF_ACQUIRE: begin
          if (last_q != SGN_NONE && cur_sign != last_q) begin
            if (rev_q < REV_W'(REV_CNT)) rev_d = rev_q + 1'b1;
            if (rev_d == REV_W'(REV_CNT)) begin
              state_d = LF_TRACK;
              rev_d   = '0;
              slip_d  = '0;
            end
          end
        end
        LF_TRACK: begin
          if (cur_sign == last_q) begin
            if (slip_q < SLIP_W'(SLIP_CNT)) slip_d = slip_q + 1'b1;
          end else begin
            slip_d = SLIP_W'(1);
          end
          if (slip_d == SLIP_W'(SLIP_CNT)) begin
            state_d = LF_ACQUIRE;
            rev_d   = '0;
            slip_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk_gen) begin
    if (i_rst) begin
      acc_q   <= ACC_INIT;
      ctrl_q  <= CTRL_INIT;
      sat_q   <= 1'b0;
      state_q <= LF_ACQUIRE;
      last_q  <= SGN_NONE;
      rev_q   <= '0;
      slip_q  <= '0;
    end else if (i_scan_en) begin
      acc_q <= {acc_q[INT_W-2:0], i_scan_in};
    end else begin
      acc_q   <= acc_sum;
      ctrl_q  <= ctrl_sum;
      sat_q   <= acc_sat;
      state_q <= state_d;
      last_q  <= last_d;
      rev_q   <= rev_d;
      slip_q  <= slip_d;
    end
  end

`ifdef TT_LF_LOCK_DET_EN
  localparam int unsigned LOCK_W = $clog2(LOCK_CYC + 1);

  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;

  // Uses next state/sat so o_locked drops on the same edge as ACQUIRE entry or a clamp.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (state_d == LF_ACQUIRE || acc_sat) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      if (lock_cnt_q < LOCK_W'(LOCK_CYC)) lock_cnt_d = lock_cnt_q + 1'b1;
      locked_d = (lock_cnt_d == LOCK_W'(LOCK_CYC));
    end
  end

  always_ff @(posedge i_clk_gen) begin
    if (i_rst) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (!i_scan_en) begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign o_locked = locked_q;
`else
  assign o_locked = 1'b0;
`endif

  assign o_ctrl     = ctrl_q;
  assign o_tracking = (state_q == LF_TRACK);
  assign o_sat      = sat_q;
  assign o_scan_out = acc_q[INT_W-1];

endmodule

// File: tb/tb_tt_loop_filter.sv
// Scoreboard bench for tt_loop_filter: a behavioural model pushes expectations, outputs pop them.
module tb_tt_loop_filter;

  localparam int ACC_MAX = 16383;

  logic       clk = 1'b0;
  logic       rst, up, down, scan_en, scan_in;
  logic [7:0] ctrl;
  logic       tracking, sat, locked, scan_out;

  always #5 clk = ~clk;

  tt_loop_filter dut (
    .i_clk_gen (clk),
    .i_rst     (rst),
    .i_up      (up),
    .i_down    (down),
    .o_ctrl    (ctrl),
    .o_tracking(tracking),
    .o_sat     (sat),
    .o_locked  (locked),
    .i_scan_en (scan_en),
    .i_scan_in (scan_in),
    .o_scan_out(scan_out)
  );

  typedef struct {
    int ctrl;
    int trk;
    int sat;
    int lck;
    int so;
    int acc;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  int m_acc, m_ctrl, m_trk, m_rev, m_slip, m_last, m_sat, m_lcnt, m_lck;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    tests_run++;
    if (obs != exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_step(input bit r, input bit u, input bit d, input bit se, input bit si);
    int   err, n, c;
    exp_t e;
    if (r) begin
      m_acc = 128 * 64; m_ctrl = 128; m_trk = 0; m_rev = 0; m_slip = 0;
      m_last = 0; m_sat = 0; m_lcnt = 0; m_lck = 0;
    end else if (se) begin
      m_acc = ((m_acc << 1) | int'(si)) & ACC_MAX;
    end else begin
      err = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
      n = m_acc + err * (m_trk ? 4 : 64);
      m_sat = (n < 0 || n > ACC_MAX) ? 1 : 0;
      if (n < 0) n = 0;
      if (n > ACC_MAX) n = ACC_MAX;
      c = n / 64 + err * (m_trk ? 1 : 4);
      if (c < 0) c = 0;
      if (c > 255) c = 255;
      m_acc = n;
      m_ctrl = c;
      if (err != 0) begin
        if (m_trk == 0) begin
          if (m_last != 0 && err != m_last) begin
            m_rev++;
            if (m_rev == 4) begin m_trk = 1; m_rev = 0; m_slip = 0; end
          end
        end else begin
          if (err == m_last) m_slip++;
          else m_slip = 1;
          if (m_slip == 8) begin m_trk = 0; m_rev = 0; m_slip = 0; end
        end
        m_last = err;
      end
`ifdef TT_LF_LOCK_DET_EN
      if (m_trk == 0 || m_sat == 1) begin
        m_lcnt = 0; m_lck = 0;
      end else if (m_lcnt < 256) begin
        m_lcnt++;
        m_lck = (m_lcnt == 256) ? 1 : 0;
      end
`endif
    end
    e.ctrl = m_ctrl; e.trk = m_trk; e.sat = m_sat; e.lck = m_lck;
    e.so = (m_acc >> 13) & 1; e.acc = m_acc;
    sb_q.push_back(e);
  endtask

  // Drive one cycle (called #1 after a posedge), then compare #1 after the next posedge.
  task automatic cyc(input bit r, input bit u, input bit d, input bit se, input bit si);
    exp_t e;
    rst = r; up = u; down = d; scan_en = se; scan_in = si;
    model_step(r, u, d, se, si);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_eq("ctrl", int'(ctrl), e.ctrl);
      check_eq("tracking", int'(tracking), e.trk);
      check_eq("sat", int'(sat), e.sat);
      check_eq("locked", int'(locked), e.lck);
      check_eq("scan_out", int'(scan_out), e.so);
      check_eq("acc", int'(dut.acc_q), e.acc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [13:0] pat;
    rst = 1'b1; up = 1'b0; down = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    #1;
    // 1: reset then idle
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 1);
    idle(10);
    check_eq("t1_ctrl", int'(ctrl), 128);
    check_eq("t1_acc", int'(dut.acc_q), 8192);
    check_eq("t1_trk", int'(tracking), 0);
    check_eq("t1_sat", int'(sat), 0);
    // 2: single up in ACQUIRE, kick lasts one cycle
    cyc(0, 1, 0, 0, 0);
    check_eq("t2_ctrl_kick", int'(ctrl), 133);
    check_eq("t2_acc", int'(dut.acc_q), 8256);
    idle(1);
    check_eq("t2_ctrl_idle", int'(ctrl), 129);
    // 3: four reversals enter TRACK, then a narrow-gain up
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(1);
    cyc(0, 1, 0, 0, 0);
    check_eq("t3_trk", int'(tracking), 1);
    idle(1);
    cyc(0, 1, 0, 0, 0);
    check_eq("t3_acc", int'(dut.acc_q), 8260);
    check_eq("t3_ctrl", int'(ctrl), 8260 / 64 + 1);
    idle(2);
    // 4: eight downs in TRACK slip back to ACQUIRE
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0);
    check_eq("t4_trk7", int'(tracking), 1);
    cyc(0, 0, 1, 0, 0);
    check_eq("t4_trk8", int'(tracking), 0);
    cyc(0, 0, 1, 0, 0);
    check_eq("t4_wide_acc", int'(dut.acc_q), 8260 - 8 * 4 - 64);
    // 5: saturate high, then both pulses together
    for (int i = 0; i < 200; i++) cyc(0, 1, 0, 0, 0);
    check_eq("t5_ctrl", int'(ctrl), 255);
    check_eq("t5_sat", int'(sat), 1);
    check_eq("t5_acc", int'(dut.acc_q), ACC_MAX);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
    check_eq("t5_both_sat", int'(sat), 0);
    idle(2);
    // 6: scan shift 0x2A5B with pulses ignored, resume, then reset during scan
    pat = 14'h2A5B;
    for (int i = 13; i >= 0; i--) cyc(0, pat[i], 1'b0, 1'b1, pat[i]);
    check_eq("t6_acc", int'(dut.acc_q), 14'h2A5B);
    idle(2);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    check_eq("t6_rst_acc", int'(dut.acc_q), 8192);
    idle(2);
    // random traffic with occasional scan and reset
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
          ($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1);
    end
    // quiet TRACK run for lock detection
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, (i % 2) == 0, (i % 2) == 1, 0, 0);
    idle(270);
`ifdef TT_LF_LOCK_DET_EN
    check_eq("t6_locked", int'(locked), 1);
`else
    check_eq("t6_locked", int'(locked), 0);
`endif
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);
    check_eq("t6_unlock", int'(locked), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tt_loop_filter.md
Name: tt_loop_filter

Overview:
- Digital PI loop filter on the consumer side of the phase frequency detector's up/down interface.
- Integrates one-cycle up/down pulses into a saturating integrator and adds a proportional kick, producing the DCO control word that closes the PLL loop.
- A two-state gain-scheduling FSM switches between wide acquisition gain and narrow tracking gain.
- Carries a scan chain through the integrator so it stays consistent with the rest of the PLL.

Parameters:
CTRL_W, 8, DCO control word width
FRAC_W, 6, integrator fractional bits; integrator width INT_W = CTRL_W+FRAC_W
INIT_CTRL, 128, control word loaded at reset
ACQ_STEP, 64, integrator step per event in ACQUIRE (integrator LSBs)
TRK_STEP, 4, integrator step per event in TRACK
KP_ACQ, 4, proportional kick in ACQUIRE (control-word LSBs)
KP_TRK, 1, proportional kick in TRACK
REV_CNT, 4, sign reversals needed to go ACQUIRE->TRACK
SLIP_CNT, 8, consecutive same-sign events that force TRACK->ACQUIRE
LOCK_CYC, 256, cycles in TRACK before o_locked (optional feature only)

Ports:
i_clk_gen  in  1  system clock, same domain as the PFD
i_rst  in  1  synchronous, active-high reset
i_up  in  1  PFD up pulse (reference leads)
i_down  in  1  PFD down pulse (divided clock leads)
o_ctrl  out  CTRL_W  DCO control word, registered
o_tracking  out  1  1 when FSM is in TRACK
o_sat  out  1  integrator sat at a bound on the last update
o_locked  out  1  lock indicator (optional feature)
i_scan_en  in  1  scan shift enable
i_scan_in  in  1  scan data in
o_scan_out  out  1  scan data out = integrator MSB

Behaviour:
- Reset is sampled on posedge i_clk_gen. It sets:
  - acc = INIT_CTRL<<FRAC_W; o_ctrl = INIT_CTRL; state = ACQUIRE.
  - o_tracking = 0; o_sat = 0; o_locked = 0; rev/slip/lock counters = 0; last_sign = none.
- Reset has priority over scan and normal operation. Reset mid-operation discards all state in one cycle.
- Error decode per cycle:
  - err = +1 if i_up && !i_down.
  - err = -1 if i_down && !i_up.
  - Otherwise err = 0; both pulses high in the same cycle counts as 0.
- Integrator:
  - acc_next = acc + err*STEP, where STEP = ACQ_STEP or TRK_STEP per the current state.
  - Computed at INT_W+1 bits signed, then clamped to [0, 2^INT_W-1].
  - o_sat <= 1 when the clamp engaged this cycle, else 0.
- Output:
  - o_ctrl <= clamp(acc_next[INT_W-1:FRAC_W] + err*KP, 0, 2^CTRL_W-1), with KP per the current state.
  - Latency is one edge from the pulse to o_ctrl. The kick lasts exactly one cycle; on the next idle cycle o_ctrl falls back to the integer part of acc.
- FSM ACQUIRE:
  - A nonzero err whose sign differs from last_sign increments rev (saturating).
  - When rev reaches REV_CNT, the FSM moves to TRACK and clears rev and slip.
- FSM TRACK:
  - A nonzero err with the same sign as last_sign increments slip; an opposite sign clears slip to 1.
  - When slip reaches SLIP_CNT, the FSM returns to ACQUIRE and clears rev and slip.
- Common FSM rules:
  - last_sign updates on every nonzero err.
  - The first event after reset is not a reversal.
  - The state change takes effect on the step/kick used in the following cycle.
- Scan (i_scan_en=1, not reset):
  - acc <= {acc[INT_W-2:0], i_scan_in}.
  - o_ctrl, FSM state, counters and o_sat all hold; i_up/i_down are ignored.
  - After scan deasserts, normal updates resume from the shifted acc.

Optional Feature:
- TT_LF_LOCK_DET_EN defined:
  - A LOCK_CYC counter runs while in TRACK and resets on any cycle with o_sat=1 or in ACQUIRE.
  - o_locked asserts when the counter reaches LOCK_CYC and holds until leaving TRACK or saturating.
  - o_locked deasserts on the same edge the FSM enters ACQUIRE.
- Not defined: the counter is not built and o_locked is tied 0.

Decomposition:
- Package tt_lf_pkg holds:
  - the state enum (LF_ACQUIRE, LF_TRACK);
  - the sign enum (SGN_NONE, SGN_POS, SGN_NEG);
  - the err-decode function.
- Sub-module tt_lf_sat_add: parameterised signed add with clamp, instanced for the integrator and the output sum.

Test Plan:
1. Reset, then idle 10 cycles -> o_ctrl=128, acc=8192, o_tracking=0, o_sat=0.
2. One i_up cycle in ACQUIRE -> next edge o_ctrl=133 and acc=8256; following idle edge o_ctrl=129.
3. Alternate up/down events 4 times -> o_tracking=1 after 4th reversal. Then one i_up -> acc +4, o_ctrl = int(acc)+1 for one cycle.
4. In TRACK, 8 consecutive i_down events -> o_tracking=0 on the 8th edge; next i_down uses step 64 and kick 4.
5. Hold i_up for 200 cycles -> o_ctrl clamps at 255, o_sat=1, and acc stays 16383. Assert i_up and i_down together -> no change.
6. Shift 14 bits 0x2A5B through scan -> o_scan_out replays the prior acc MSB-first and acc=0x2A5B; i_rst during scan -> acc=8192. With TT_LF_LOCK_DET_EN, 256 quiet TRACK cycles -> o_locked=1.
